// File: rtl/bp_fe_queue_rollback_buffer_if.sv
// Handshake bundle between the fetch front end, the BE issue/commit logic and the rollback queue.
interface bp_fe_queue_rollback_buffer_if #(
  parameter int unsigned els_p        = 8,
  parameter int unsigned data_width_p = 128
);
  localparam int unsigned ptr_width_lp = $clog2(els_p) + 1;

  logic [data_width_p-1:0] fe_queue_i;
  logic                    fe_queue_v_i;
  logic                    fe_queue_ready_o;
  logic [data_width_p-1:0] fe_queue_o;
  logic                    fe_queue_v_o;
  logic                    fe_queue_yumi_i;
  logic                    deq_i;
  logic                    roll_i;
  logic                    clr_i;
  logic [ptr_width_lp-1:0] count_o;

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, deq_i, roll_i, clr_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, count_o
  );

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, deq_i, roll_i, clr_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, count_o
  );
endinterface

// File: rtl/bp_fe_queue_rollback_buffer.sv
// FE-to-BE instruction queue with speculative issue, in-order commit, replay (roll) and flush (clr).
module bp_fe_queue_rollback_buffer #(
  parameter int unsigned els_p        = 8,
  parameter int unsigned data_width_p = 128
) (
  input logic                          clk_i,
  input logic                          reset_n_i,
  bp_fe_queue_rollback_buffer_if.slave queue_if
);
  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam int unsigned ptr_width_lp = idx_width_lp + 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;

  if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
    $error("bp_fe_queue_rollback_buffer: els_p must be a power of 2 and >= 2");
  end

  logic [data_width_p-1:0] mem [els_p];

  ptr_t wptr_r, rptr_r, cptr_r;
  ptr_t wptr_n, rptr_n, cptr_n;
  logic ready_r, ready_n;
  logic wr_en;
  logic enq;
  logic valid;

  assign enq   = queue_if.fe_queue_v_i & ready_r;
  assign valid = (rptr_r != wptr_r);

  // Next-pointer selection: clr beats roll beats the independent updates.
  always_comb begin
    wptr_n = wptr_r;
    rptr_n = rptr_r;
    cptr_n = cptr_r;
    wr_en  = 1'b0;
    if (queue_if.clr_i) begin
      rptr_n = wptr_r;
      cptr_n = wptr_r;
    end else begin
      if (enq) begin
        wr_en  = 1'b1;
        wptr_n = wptr_r + ptr_t'(1);
      end
      cptr_n = cptr_r + ptr_t'(queue_if.deq_i);
      if (queue_if.roll_i) begin
        rptr_n = cptr_n;
      end else if (queue_if.fe_queue_yumi_i) begin
        rptr_n = rptr_r + ptr_t'(1);
      end
    end
    // Ready is registered from next state so it never follows an input combinationally.
    ready_n = ((wptr_n - cptr_n) != ptr_t'(els_p));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      cptr_r  <= '0;
      ready_r <= 1'b0;
    end else begin
      wptr_r  <= wptr_n;
      rptr_r  <= rptr_n;
      cptr_r  <= cptr_n;
      ready_r <= ready_n;
    end
  end

  // Entry storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wptr_r[idx_width_lp-1:0]] <= queue_if.fe_queue_i;
    end
  end

  assign queue_if.fe_queue_ready_o = ready_r;
  assign queue_if.fe_queue_v_o     = valid;
  assign queue_if.fe_queue_o       = valid ? mem[rptr_r[idx_width_lp-1:0]] : '0;
  assign queue_if.count_o          = wptr_r - cptr_r;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    queue_if.fe_queue_yumi_i |-> valid)
    else $error("fe_queue_yumi_i asserted while fe_queue_v_o is low");

  a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    queue_if.deq_i |-> (cptr_r != rptr_r))
    else $error("deq_i asserted with no issued, uncommitted entry");
endmodule

// File: tb/tb_bp_fe_queue_rollback_buffer.sv
// Directed scenarios plus randomized traffic against a queue-level model of the rollback buffer.
module tb_bp_fe_queue_rollback_buffer;
  localparam int unsigned ELS = 8;
  localparam int unsigned DW  = 128;
  localparam int unsigned PW  = $clog2(ELS) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_fe_queue_rollback_buffer_if #(.els_p(ELS), .data_width_p(DW)) qif ();

  bp_fe_queue_rollback_buffer #(.els_p(ELS), .data_width_p(DW)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .queue_if  (qif.slave)
  );

  // Model: retained entries oldest-first, and how many of them are issued.
  logic [DW-1:0] ent[$];
  int            issued;
  bit            m_ready;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_outputs(input string tag);
    bit            exp_v;
    logic [DW-1:0] exp_d;
    exp_v = (issued < ent.size());
    exp_d = exp_v ? ent[issued] : '0;
    chk({tag, "_v"},     DW'(qif.fe_queue_v_o),     DW'(exp_v));
    chk({tag, "_data"},  qif.fe_queue_o,            exp_d);
    chk({tag, "_count"}, DW'(qif.count_o),          DW'(ent.size()));
    chk({tag, "_ready"}, DW'(qif.fe_queue_ready_o), DW'(m_ready));
  endtask

  task automatic idle_inputs();
    qif.fe_queue_i      = '0;
    qif.fe_queue_v_i    = 1'b0;
    qif.fe_queue_yumi_i = 1'b0;
    qif.deq_i           = 1'b0;
    qif.roll_i          = 1'b0;
    qif.clr_i           = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input string tag, input bit v, input logic [DW-1:0] d,
                      input bit y, input bit dq, input bit rl, input bit cl);
    bit enq;
    qif.fe_queue_i      = d;
    qif.fe_queue_v_i    = v;
    qif.fe_queue_yumi_i = y;
    qif.deq_i           = dq;
    qif.roll_i          = rl;
    qif.clr_i           = cl;
    enq = v && m_ready;
    if (cl) begin
      ent.delete();
      issued = 0;
    end else begin
      if (dq) begin
        void'(ent.pop_front());
        issued--;
      end
      if (rl) issued = 0;
      else if (y) issued++;
      if (enq) ent.push_back(d);
    end
    m_ready = (ent.size() != ELS);
    @(posedge clk);
    #1;
    idle_inputs();
    check_outputs(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && ent.size() > 0; i++)
      step(tag, 1'b0, '0, issued < ent.size(), issued > 0, 1'b0, 1'b0);
  endtask

  function automatic logic [DW-1:0] val(input int i);
    return {DW'(32'hA000_0000 + 32'(i)) << 64} | DW'(32'(i) * 32'h0101);
  endfunction

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_v"},     DW'(qif.fe_queue_v_o),     '0);
    chk({tag, "_data"},  qif.fe_queue_o,            '0);
    chk({tag, "_count"}, DW'(qif.count_o),          '0);
    chk({tag, "_ready"}, DW'(qif.fe_queue_ready_o), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    ent.delete();
    issued  = 0;
    m_ready = 1'b0;

    // 1: reset state, then in-order issue and commit
    #2;
    reset_outputs_check("rst");
    #10;
    rst_n = 1'b1;
    step("t1_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("t1_enq", 1'b1, val(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_first", qif.fe_queue_o, val(0));
    for (int i = 0; i < 3; i++) step("t1_yumi", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("t1_deq", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_end_v", DW'(qif.fe_queue_v_o), '0);

    // 2: fill to capacity, offered entry refused while full, ready returns after a commit
    for (int i = 0; i < ELS; i++) step("t2_fill", 1'b1, val(10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_full_count", DW'(qif.count_o), DW'(ELS));
    chk("t2_full_ready", DW'(qif.fe_queue_ready_o), '0);
    step("t2_refuse", 1'b1, val(99), 1'b1, 1'b0, 1'b0, 1'b0);
    step("t2_deq", 1'b1, val(98), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_ready_back", DW'(qif.fe_queue_ready_o), DW'(1));
    drain("t2_drain");

    // 3: roll back to the oldest uncommitted entry and replay
    for (int i = 0; i < 5; i++) step("t3_enq", 1'b1, val(20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("t3_yumi", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t3_roll", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_replay_a", qif.fe_queue_o, val(20));
    for (int i = 0; i < 5; i++) begin
      chk("t3_reissue", qif.fe_queue_o, val(20 + i));
      step("t3_yumi2", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_count5", DW'(qif.count_o), DW'(5));
    end
    drain("t3_drain");

    // 4: deq and roll together commit first, then rewind
    for (int i = 0; i < 5; i++) step("t4_enq", 1'b1, val(30 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("t4_yumi", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t4_deqroll", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_b", qif.fe_queue_o, val(31));
    chk("t4_count4", DW'(qif.count_o), DW'(4));
    drain("t4_drain");

    // 5: flush drops the concurrent enqueue
    step("t5_enq", 1'b1, val(40), 1'b0, 1'b0, 1'b0, 1'b0);
    step("t5_enq", 1'b1, val(41), 1'b1, 1'b0, 1'b0, 1'b0);
    step("t5_clr", 1'b1, val(42), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_clr_v", DW'(qif.fe_queue_v_o), '0);
    chk("t5_clr_count", DW'(qif.count_o), '0);
    step("t5_enq_d", 1'b1, val(43), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_d", qif.fe_queue_o, val(43));
    step("t5_yumi", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t5_deq", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 6: random traffic through several pointer wraps, then reset mid-stream
    for (int i = 0; i < 80; i++) begin
      bit v, y, dq, rl, cl;
      v  = ($urandom_range(99) < 85);
      y  = (issued < ent.size()) && ($urandom_range(99) < 75);
      dq = (issued > 0) && ($urandom_range(99) < 70);
      rl = ($urandom_range(99) < 6);
      cl = ($urandom_range(99) < 3);
      step("t6_rand", v, {$urandom, $urandom, $urandom, $urandom}, y, dq, rl, cl);
    end
    qif.fe_queue_v_i = 1'b1;
    qif.fe_queue_i   = val(77);
    #2;
    rst_n = 1'b0;
    #1;
    reset_outputs_check("t6_rst");
    idle_inputs();
    ent.delete();
    issued  = 0;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("t6_in_rst");
    rst_n = 1'b1;
    step("t6_post", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
